// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the RV64 data memory unit. Provides
//               the array geometry, the largest byte address the core will
//               present, and the RUN/DUMP/DONE state encoding used by the
//               dump sequencer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_DEPTH    = 1024;  // 64-bit words
  localparam int DMEM_AW       = 10;    // clog2(DMEM_DEPTH)
  localparam int DMEM_MAX_ADDR = 8185;  // core clamps anything above to 0

  // Explicitly encoded so the state register width and values are fixed.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_dump_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dump_fsm
// Description : Halt-triggered dump sequencer. Holds the RUN/DUMP/DONE state,
//               the dump word counter and the valid/ready handshake. The
//               counter doubles as the array read index for the dump port.
// Ports       : clk, rst          - clock, async active-high reset
//               i_halt            - core halted (level)
//               i_dump_ready      - consumer accepts current dump word
//               o_state           - current sequencer state
//               o_dump_valid      - dump word present
//               o_dump_addr       - word index being presented
//               o_dump_done       - all words delivered (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_halt,
  input  logic          i_dump_ready,
  output dmem_state_e   o_state,
  output logic          o_dump_valid,
  output logic [AW-1:0] o_dump_addr,
  output logic          o_dump_done
);

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  dmem_state_e   r_state;
  logic [AW-1:0] r_dump_addr;

  // Valid is decoded purely from state, so it can only fall when the state
  // leaves DUMP, which only happens on a handshake of the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_dump_addr <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_halt) begin
            r_state     <= ST_DUMP;
            r_dump_addr <= '0;
          end
        end
        ST_DUMP: begin
          if (i_dump_ready) begin
            r_dump_addr <= r_dump_addr + AW'(1);
            if (r_dump_addr == c_last_idx) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_dump_valid = (r_state == ST_DUMP);
  assign o_dump_done  = (r_state == ST_DONE);
  assign o_dump_addr  = r_dump_addr;

endmodule : dmem_dump_fsm
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_unit
// Description : Data memory for the 5-stage RV64 pipeline. Combinational read
//               onto the shared bidirectional bus, clocked write, halt-time
//               dump of the whole array over a valid/ready port, saturating
//               access counters and a sticky misalignment flag.
// Ports       : clk, rst          - clock, async active-high reset
//               mem_rw            - 1: core drives mem_data (store)
//               addr              - byte address from EX/MEM
//               mem_data          - shared 64-bit bus (inout)
//               halt              - core halted (level)
//               dump_ready        - dump consumer ready
//               dump_valid/addr/data/done - dump port
//               err               - sticky misaligned-store flag
//               rd_cnt, wr_cnt    - saturating load/store counters
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_rw,
  input  logic [63:0]   addr,
  inout  wire  [63:0]   mem_data,
  input  logic          halt,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [63:0]   dump_data,
  output logic          dump_done,
  output logic          err,
  output logic [31:0]   rd_cnt,
  output logic [31:0]   wr_cnt
);

  // Storage has no reset on purpose: contents must survive rst.
  logic [63:0]   r_mem [DEPTH];
  logic          r_err;
  logic [31:0]   r_rd_cnt;
  logic [31:0]   r_wr_cnt;

  dmem_state_e   w_state;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_dump_addr;
  logic          w_run;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_bus_drive;
  logic          w_misaligned;

  dmem_dump_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dump_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_halt       (halt),
    .i_dump_ready (dump_ready),
    .o_state      (w_state),
    .o_dump_valid (dump_valid),
    .o_dump_addr  (w_dump_addr),
    .o_dump_done  (dump_done)
  );

  // Only the word-index bits select the entry; upper bits are out of range
  // by construction and the low three bits only matter for the error flag.
  assign w_idx        = addr[AW+2:3];
  assign w_misaligned = (addr[2:0] != 3'b000);
  assign w_run        = (w_state == ST_RUN);
  assign w_wr_en      = w_run && mem_rw;
  // Address 0 is the core's idle/NOP encoding, so it is not a counted load.
  assign w_rd_en      = w_run && !mem_rw && (addr != 64'd0);
  assign w_bus_drive  = w_run && !mem_rw;

  assign mem_data  = w_bus_drive ? r_mem[w_idx] : 64'hz;
  assign dump_addr = w_dump_addr;
  assign dump_data = r_mem[w_dump_addr];

  // The halt cycle is still RUN, so a store issued alongside halt commits.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_wr_en && w_misaligned) begin
        r_err <= 1'b1;
      end
      if (w_wr_en && (r_wr_cnt != 32'hFFFF_FFFF)) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
      if (w_rd_en && (r_rd_cnt != 32'hFFFF_FFFF)) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
    end
  end

  assign err    = r_err;
  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;

endmodule : data_mem_unit
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Directed self-checking bench for data_mem_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_unit;

  logic        clk;
  logic        rst;
  logic        mem_rw;
  logic [63:0] addr;
  logic [63:0] tb_data;
  wire  [63:0] mem_data;
  logic        halt;
  logic        dump_ready;
  logic        dump_valid;
  logic [9:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_done;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks;
  int n_errors;

  assign mem_data = mem_rw ? tb_data : 64'hz;

  data_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rw     (mem_rw),
    .addr       (addr),
    .mem_data   (mem_data),
    .halt       (halt),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .err        (err),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic rw, input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    mem_rw  = rw;
    addr    = a;
    tb_data = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_rw = 1'b0; addr = 64'd0; tb_data = 64'd0;
    halt = 1'b0; dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (dump_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0h want 0", dump_valid); end
    n_checks++; if (dump_addr !== 10'd0) begin n_errors++; $display("FAIL rst_daddr: got %0h want 0", dump_addr); end
    n_checks++; if (dump_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %0h want 0", dump_done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %0h want 0", err); end
    n_checks++; if (rd_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_rdcnt: got %0h want 0", rd_cnt); end
    n_checks++; if (wr_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_wrcnt: got %0h want 0", wr_cnt); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rd_cnt !== 32'd0) begin n_errors++; $display("FAIL idle_rdcnt: got %0h want 0", rd_cnt); end
  endtask

  task automatic test_store_load;
    drive(1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567);
    drive(1'b0, 64'h40, 64'd0);
    #1;
    n_checks++; if (mem_data !== 64'hDEAD_BEEF_0123_4567) begin n_errors++; $display("FAIL load_same_cycle: got %h want deadbeef01234567", mem_data); end
    drive(1'b0, 64'd0, 64'd0);
    #1;
    n_checks++; if (wr_cnt !== 32'd1) begin n_errors++; $display("FAIL sl_wrcnt: got %0d want 1", wr_cnt); end
    n_checks++; if (rd_cnt !== 32'd1) begin n_errors++; $display("FAIL sl_rdcnt: got %0d want 1", rd_cnt); end
  endtask

  task automatic test_misaligned;
    drive(1'b1, 64'h43, 64'h1122_3344_5566_7788);
    drive(1'b0, 64'h40, 64'd0);
    #1;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mis_err: got %0h want 1", err); end
    n_checks++; if (mem_data !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL mis_word8: got %h want 1122334455667788", mem_data); end
    drive(1'b0, 64'd0, 64'd0);
    repeat (100) @(negedge clk);
    #1;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL mis_sticky: got %0h want 1", err); end
    n_checks++; if (wr_cnt !== 32'd2) begin n_errors++; $display("FAIL mis_wrcnt: got %0d want 2", wr_cnt); end
    n_checks++; if (rd_cnt !== 32'd2) begin n_errors++; $display("FAIL mis_rdcnt: got %0d want 2", rd_cnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL mis_err_rst: got %0h want 0", err); end
    n_checks++; if (wr_cnt !== 32'd0) begin n_errors++; $display("FAIL mis_wrcnt_rst: got %0d want 0", wr_cnt); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 64'h40, 64'd0);
    #1;
    n_checks++; if (mem_data !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL mem_survives_rst: got %h want 1122334455667788", mem_data); end
    drive(1'b0, 64'd0, 64'd0);
  endtask

  // mem[i] = i for i < 1023; word 1023 is written in the halt cycle.
  task automatic test_preload;
    for (int i = 0; i < 1023; i++) begin
      drive(1'b1, 64'(i * 8), 64'(i));
    end
    drive(1'b0, 64'd0, 64'd0);
    #1;
    n_checks++; if (wr_cnt !== 32'd1023) begin n_errors++; $display("FAIL preload_wrcnt: got %0d want 1023", wr_cnt); end
  endtask

  task automatic test_dump_full;
    drive(1'b1, 64'(1023 * 8), 64'd1023);
    halt = 1'b1;
    dump_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      // A store during the dump aimed at a word not yet dumped.
      mem_rw  = (i == 10);
      addr    = (i == 10) ? 64'(1000 * 8) : 64'd0;
      tb_data = 64'hFFFF;
      #1;
      n_checks++; if (dump_valid !== 1'b1) begin n_errors++; $display("FAIL dump_valid[%0d]: got %0h want 1", i, dump_valid); end
      n_checks++; if (dump_addr !== 10'(i)) begin n_errors++; $display("FAIL dump_addr[%0d]: got %0d want %0d", i, dump_addr, i); end
      n_checks++; if (dump_data !== 64'(i)) begin n_errors++; $display("FAIL dump_data[%0d]: got %0h want %0h", i, dump_data, i); end
    end
    @(negedge clk);
    mem_rw = 1'b0;
    halt = 1'b0;
    #1;
    n_checks++; if (dump_done !== 1'b1) begin n_errors++; $display("FAIL dump_done: got %0h want 1", dump_done); end
    n_checks++; if (dump_valid !== 1'b0) begin n_errors++; $display("FAIL done_valid: got %0h want 0", dump_valid); end
    n_checks++; if (wr_cnt !== 32'd1024) begin n_errors++; $display("FAIL dump_wrcnt: got %0d want 1024", wr_cnt); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin n_errors++; $display("FAIL done_hold: got done=%0h valid=%0h want done=1 valid=0", dump_done, dump_valid); end
  endtask

  task automatic test_rst_mid_dump;
    int found;
    int exp;
    logic [3:0] pat;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    halt = 1'b1;
    dump_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      @(negedge clk);
      #1;
      if (dump_valid === 1'b1 && dump_addr === 10'd500) found = 1;
    end
    n_checks++; if (found != 1) begin n_errors++; $display("FAIL reach_500: got %0d want 1", found); end
    n_checks++; if (dump_data !== 64'd500) begin n_errors++; $display("FAIL data_500: got %0d want 500", dump_data); end
    rst = 1'b1;
    halt = 1'b0;
    #1;
    n_checks++; if (dump_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %0h want 0", dump_valid); end
    n_checks++; if (dump_addr !== 10'd0) begin n_errors++; $display("FAIL mid_rst_daddr: got %0d want 0", dump_addr); end
    n_checks++; if (dump_done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_done: got %0h want 0", dump_done); end
    n_checks++; if (wr_cnt !== 32'd0 || rd_cnt !== 32'd0 || err !== 1'b0) begin n_errors++; $display("FAIL mid_rst_stat: got wr=%0d rd=%0d err=%0h want 0 0 0", wr_cnt, rd_cnt, err); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 64'd4000, 64'd0);
    #1;
    n_checks++; if (mem_data !== 64'd500) begin n_errors++; $display("FAIL mem500_kept: got %0d want 500", mem_data); end
    drive(1'b0, 64'd0, 64'd0);
    halt = 1'b1;
    dump_ready = 1'b0;
    // Ready pattern 1,0,0,1 repeating; index advances only on ready cycles.
    pat = 4'b1001;
    exp = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      dump_ready = pat[k % 4];
      #1;
      n_checks++; if (dump_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d]: got %0h want 1", k, dump_valid); end
      n_checks++; if (dump_addr !== 10'(exp)) begin n_errors++; $display("FAIL stall_addr[%0d]: got %0d want %0d", k, dump_addr, exp); end
      n_checks++; if (dump_data !== 64'(exp)) begin n_errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", k, dump_data, exp); end
      if (dump_ready) exp++;
    end
  endtask

  task automatic test_wr_sat;
    @(negedge clk);
    halt = 1'b0;
    dump_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    force dut.r_wr_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_wr_cnt;
    drive(1'b1, 64'h8, 64'hA1);
    drive(1'b0, 64'd0, 64'd0);
    #1;
    n_checks++; if (wr_cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_first: got %h want ffffffff", wr_cnt); end
    drive(1'b1, 64'h10, 64'hA2);
    drive(1'b1, 64'h18, 64'hA3);
    drive(1'b0, 64'h10, 64'd0);
    #1;
    n_checks++; if (wr_cnt !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL sat_hold: got %h want ffffffff", wr_cnt); end
    n_checks++; if (mem_data !== 64'hA2) begin n_errors++; $display("FAIL sat_store_data: got %h want a2", mem_data); end
    drive(1'b0, 64'd0, 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_preload();
    test_dump_full();
    test_rst_mid_dump();
    test_wr_sat();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_data_mem_unit
`default_nettype wire

// File: doc/data_mem_unit.md
# data_mem_unit

Data memory for the 5-stage RV64 pipeline. It sits directly downstream of the core's MEM stage and services the shared bidirectional 64-bit `mem_data` bus: combinational read, write on the clock edge. Once the core signals `halt`, it streams its entire contents out over a valid/ready dump port so the bench or host can check results. It also keeps saturating access counters and a sticky error flag.

## Interface
- `DEPTH`, 1024, number of 64-bit words (8192 bytes).
- `AW`, 10, word-index width, equal to clog2(`DEPTH`).
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_rw` input 1: 1 = core drives `mem_data` (store); 0 = this block drives it (load/idle).
- `addr` input 64: byte address from the core's EX/MEM result. The core already forces values above 8185 to 0.
- `mem_data` inout 64: shared data bus.
- `halt` input 1: core halted. Level signal that stays high once asserted.
- `dump_ready` input 1: consumer accepts the current dump word.
- `dump_valid` output 1: dump word present.
- `dump_addr` output AW: word index of `dump_data`.
- `dump_data` output 64: memory word.
- `dump_done` output 1: all `DEPTH` words delivered. Sticky until reset.
- `err` output 1: sticky; misaligned access seen (`addr[2:0]` != 0 on a store).
- `rd_cnt`, `wr_cnt` output 32 each: saturating load/store counts.

## Operation
- Word index `idx` = `addr[AW+2:3]`. Bits above are ignored, bits [2:0] are ignored for data.
- States:
  - RUN (reset state)
  - DUMP
  - DONE
- RUN, `mem_rw`=1:
  - at posedge, `mem[idx]` <= `mem_data`
  - `wr_cnt`++ (saturates at 0xFFFF_FFFF)
  - if `addr[2:0]`!=0 then `err`<=1
  - block does not drive the bus (`mem_data` = z from this side)
- RUN, `mem_rw`=0:
  - `mem_data` = `mem[idx]`, combinationally, same cycle
  - `rd_cnt`++ only when `addr`!=0; address 0 is treated as idle/NOP
- RUN -> DUMP: at the first posedge with `halt`=1.
  - A store with `mem_rw`=1 in that same cycle still commits.
  - `dump_addr` <= 0.
- DUMP:
  - `mem_data` released to z; further stores are ignored and not counted
  - `dump_valid`=1, `dump_data`=`mem[dump_addr]`
  - on the `dump_valid`&`dump_ready` edge: `dump_addr`++
  - if `dump_addr`==`DEPTH`-1 at that edge, go to DONE
- DONE:
  - `dump_valid`=0, `dump_done`=1
  - bus released; stays here until `rst`
- `halt` dropping during DUMP/DONE is ignored.
- Memory array is NOT cleared by reset. Contents survive `rst`.

## Timing
- Read latency 0: `mem_data` is valid in the same cycle as `addr`, because the core samples it at the next edge.
- Write latency 1: a read of the same word in the cycle after a store returns the new value.
- Dump throughput: 1 word/cycle with `dump_ready` held high. Entry into DUMP takes 1 cycle after `halt`.
- Dump port rules:
  - `dump_data`/`dump_addr` stay stable while `dump_valid`&!`dump_ready`
  - `dump_valid` never drops without a handshake
- Reset values:
  - state=RUN, `dump_valid`=0, `dump_addr`=0, `dump_data`=`mem[0]` (don't-care while not valid)
  - `dump_done`=0, `err`=0, `rd_cnt`=`wr_cnt`=0
  - bus driven with the read of `mem[idx]` when `mem_rw`=0
- `rst` mid-dump: return to RUN and restart index at 0 on the next halt. Memory is untouched.
- Counters saturate; no wrap.

## Structure
- Shared package `dmem_pkg`: state enum (RUN/DUMP/DONE), `DMEM_DEPTH`=1024, `DMEM_AW`=10, `DMEM_MAX_ADDR`=8185.
- One natural sub-module: `dmem_dump_fsm`. It holds the state, `dump_addr` counter and valid/ready handshake, and gives the array a read index. The array, bus tri-state and counters stay in `data_mem_unit`.

## Test plan
- Store 0xDEAD_BEEF_0123_4567 at `addr`=0x40, then load 0x40 next cycle -> `mem_data`=0xDEAD_BEEF_0123_4567 in the same cycle; `wr_cnt`=1, `rd_cnt`=1.
- Store at `addr`=0x43 -> `mem[8]` written, `err`=1 and stays 1 after 100 idle cycles; clears only on `rst`.
- Preload `mem[i]`=i, assert `halt` with `dump_ready`=1 -> 1024 handshakes, `dump_addr`/`dump_data` = i/i in order, `dump_done`=1 on the cycle after index 1023.
- Dump with `dump_ready` toggled 1,0,0,1... -> no word skipped or repeated; data stable during stalls.
- Assert `rst` at dump index 500 -> outputs back to reset values, `mem[500]` still 500; re-halt restarts at index 0.
- Force `wr_cnt` to 0xFFFF_FFFE and issue 3 stores -> `wr_cnt`=0xFFFF_FFFF; stores during DUMP leave memory unchanged.
